// File: rtl/regwb.sv
// Write-back queue: buffers execute/load results in a small FIFO and retires
// at most one registered write per cycle to the global or local register file.
package regwb_pkg;
  typedef struct packed {
    logic        enable;
    logic [7:0]  addr;
    logic [63:0] data;
  } regwrite_t;
endpackage

module regwb #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic                     a_local,
  input  logic [7:0]               a_addr,
  input  logic [63:0]              a_data,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic                     m_local,
  input  logic [7:0]               m_addr,
  input  logic [63:0]              m_data,
  input  logic                     hold,
  output regwb_pkg::regwrite_t     gregw,
  output regwb_pkg::regwrite_t     lregw,
  input  logic                     q_local,
  input  logic [7:0]               q_addr,
  output logic                     q_pending,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          mem_local [DEPTH];
  logic [7:0]    mem_addr  [DEPTH];
  logic [63:0]   mem_data  [DEPTH];

  logic          not_full;
  logic          push_m;
  logic          push_a;
  logic          push;
  logic          pop;
  logic          in_local;
  logic [7:0]    in_addr;
  logic [63:0]   in_data;

  always_comb begin
    not_full = (count < FULL);
    m_ready  = ~reset & not_full;
    a_ready  = ~reset & not_full & ~m_valid;
    push_m   = m_valid & m_ready;
    push_a   = a_valid & a_ready;
    push     = push_m | push_a;
    pop      = (count != '0) & ~hold;
    in_local = push_m ? m_local : a_local;
    in_addr  = push_m ? m_addr  : a_addr;
    in_data  = push_m ? m_data  : a_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by count/rd_ptr alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_local[wr_ptr] <= in_local;
      mem_addr[wr_ptr]  <= in_addr;
      mem_data[wr_ptr]  <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gregw <= '0;
      lregw <= '0;
    end else begin
      gregw.enable <= 1'b0;
      lregw.enable <= 1'b0;
      if (pop) begin
        if (mem_local[rd_ptr])
          lregw <= '{enable: 1'b1, addr: mem_addr[rd_ptr], data: mem_data[rd_ptr]};
        else
          gregw <= '{enable: 1'b1, addr: mem_addr[rd_ptr], data: mem_data[rd_ptr]};
      end
    end
  end

  // Slot i is occupied when its distance from the head is below count.
  always_comb begin
    logic [PW-1:0] off;
    off = '0;
    q_pending = (gregw.enable & ~q_local & (gregw.addr == q_addr)) |
                (lregw.enable &  q_local & (lregw.addr == q_addr));
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (({1'b0, off} < count) && (mem_local[i] == q_local) && (mem_addr[i] == q_addr))
        q_pending = 1'b1;
    end
  end
endmodule

// File: tb/tb_regwb.sv
// Scoreboarded bench for regwb: stimulus queues expected writes, a monitor
// checks every retired write in order; directed checks cover ready/count/pending.
module tb_regwb;
  import regwb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, a_local;
  logic [7:0]  a_addr;
  logic [63:0] a_data;
  logic        m_valid, m_ready, m_local;
  logic [7:0]  m_addr;
  logic [63:0] m_data;
  logic        hold;
  regwrite_t   gregw, lregw;
  logic        q_local;
  logic [7:0]  q_addr;
  logic        q_pending;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;
  logic [72:0] sb[$];

  always #5 clk = ~clk;

  regwb #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_local(a_local), .a_addr(a_addr), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_local(m_local), .m_addr(m_addr), .m_data(m_data),
    .hold(hold), .gregw(gregw), .lregw(lregw),
    .q_local(q_local), .q_addr(q_addr), .q_pending(q_pending), .count(count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_write(input logic l, input logic [7:0] a, input logic [63:0] d);
    logic [72:0] e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_write: got local=%0d addr=0x%0h data=0x%0h, no write expected (t=%0t)",
               l, a, d, $time);
    end else begin
      e = sb.pop_front();
      if ({l, a, d} !== e) begin
        miscompares++;
        $display("FAIL write_order: got local=%0d addr=0x%0h data=0x%0h, expected local=%0d addr=0x%0h data=0x%0h",
                 l, a, d, e[72], e[71:64], e[63:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (gregw.enable) check_write(1'b0, gregw.addr, gregw.data);
    if (lregw.enable) check_write(1'b1, lregw.addr, lregw.data);
  end

  task automatic drive_a(input logic l, input logic [7:0] a, input logic [63:0] d);
    a_valid = 1'b1;
    a_local = l;
    a_addr  = a;
    a_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    a_valid = 0; a_local = 0; a_addr = 0; a_data = 0;
    m_valid = 0; m_local = 0; m_addr = 0; m_data = 0;
    hold = 0; q_local = 0; q_addr = 0;
    #2;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_gregw_en", gregw.enable, 0);
    chk("rst_lregw_en", lregw.enable, 0);
    chk("rst_q_pending", q_pending, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_a_ready", a_ready, 1);
    chk("rel_m_ready", m_ready, 1);

    // single execute push, 2-edge latency to commit
    @(negedge clk);
    drive_a(1'b0, 8'h20, 64'h1234);
    sb.push_back({1'b0, 8'h20, 64'h1234});
    #1 chk("t1_a_ready", a_ready, 1);
    @(negedge clk);
    a_valid = 0;
    chk("t1_count", count, 1);
    chk("t1_gen_e0", gregw.enable, 0);
    @(negedge clk);
    chk("t1_gen_e1", gregw.enable, 1);
    chk("t1_gaddr", gregw.addr, 8'h20);
    chk("t1_len", lregw.enable, 0);
    @(negedge clk);
    chk("t1_gen_e2", gregw.enable, 0);
    chk("t1_count_done", count, 0);

    // load path wins arbitration
    @(negedge clk);
    m_valid = 1; m_local = 1; m_addr = 8'h05; m_data = 64'hAA;
    drive_a(1'b0, 8'h06, 64'hBB);
    sb.push_back({1'b1, 8'h05, 64'hAA});
    #1;
    chk("t2_a_ready", a_ready, 0);
    chk("t2_m_ready", m_ready, 1);
    @(negedge clk);
    m_valid = 0;
    sb.push_back({1'b0, 8'h06, 64'hBB});
    #1 chk("t2_a_ready_retry", a_ready, 1);
    @(negedge clk);
    a_valid = 0;
    repeat (3) @(negedge clk);
    chk("t2_count_done", count, 0);

    // fill with hold, then drain in order
    hold = 1;
    for (int i = 0; i < 4; i++) begin
      drive_a((i % 2) == 1, 8'(8'h40 + i), 64'(64'h100 + i));
      sb.push_back({1'((i % 2) == 1), 8'(8'h40 + i), 64'(64'h100 + i)});
      @(negedge clk);
    end
    drive_a(1'b0, 8'h44, 64'h104);
    #1;
    chk("t3_count_full", count, 4);
    chk("t3_a_ready_full", a_ready, 0);
    chk("t3_m_ready_full", m_ready, 0);
    @(negedge clk);
    chk("t3_count_held", count, 4);
    a_valid = 0;
    hold = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_drain_count", count, 64'(3 - i));
      chk("t3_drain_en", gregw.enable | lregw.enable, 1);
    end
    @(negedge clk);
    chk("t3_drain_idle", gregw.enable | lregw.enable, 0);

    // continuous push/pop, pointers wrap
    for (int i = 0; i < 10; i++) begin
      drive_a((i % 2) == 1, 8'(i), 64'(64'h9000 + i));
      sb.push_back({1'((i % 2) == 1), 8'(i), 64'(64'h9000 + i)});
      @(negedge clk);
      chk("t4_count", count, 1);
      if (i > 0) chk("t4_no_gap", gregw.enable | lregw.enable, 1);
    end
    a_valid = 0;
    repeat (3) @(negedge clk);
    chk("t4_count_done", count, 0);

    // pending query
    hold = 1;
    drive_a(1'b1, 8'h30, 64'h3030);
    sb.push_back({1'b1, 8'h30, 64'h3030});
    q_local = 1; q_addr = 8'h30;
    #1 chk("t5_pend_pre_edge", q_pending, 0);
    @(negedge clk);
    a_valid = 0;
    #1 chk("t5_pend_queued", q_pending, 1);
    q_local = 0;
    #1 chk("t5_pend_wrong_class", q_pending, 0);
    q_local = 1; q_addr = 8'h31;
    #1 chk("t5_pend_wrong_addr", q_pending, 0);
    q_addr = 8'h30;
    hold = 0;
    #1 chk("t5_pend_queued2", q_pending, 1);
    @(negedge clk);
    #1;
    chk("t5_len_stage", lregw.enable, 1);
    chk("t5_pend_stage", q_pending, 1);
    chk("t5_count_stage", count, 0);
    @(negedge clk);
    #1 chk("t5_pend_after", q_pending, 0);

    // asynchronous reset mid-drain
    @(negedge clk);
    hold = 1;
    for (int i = 0; i < 4; i++) begin
      drive_a((i % 2) == 1, 8'(8'h50 + i), 64'(64'h500 + i));
      sb.push_back({1'((i % 2) == 1), 8'(8'h50 + i), 64'(64'h500 + i)});
      @(negedge clk);
    end
    a_valid = 0;
    hold = 0;
    @(negedge clk);
    q_local = 1; q_addr = 8'h51;
    #1;
    chk("t6_count_pre", count, 3);
    chk("t6_gen_pre", gregw.enable, 1);
    chk("t6_pend_pre", q_pending, 1);
    #1;
    reset = 1;
    sb.delete();
    #1;
    chk("t6_gen_rst", gregw.enable, 0);
    chk("t6_len_rst", lregw.enable, 0);
    chk("t6_count_rst", count, 0);
    chk("t6_pend_rst", q_pending, 0);
    chk("t6_a_ready_rst", a_ready, 0);
    chk("t6_m_ready_rst", m_ready, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    repeat (6) @(negedge clk);
    chk("t6_count_after", count, 0);
    chk("sb_empty", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regwb.md
# regwb

Write-back queue that feeds the global and local register-file write ports. It accepts results from the execute stage and the load path over valid/ready handshakes and buffers them in a small FIFO. It retires at most one write per cycle as a registered `regwrite` onto `gregw` or `lregw`. A combinational pending query lets issue logic detect read-after-write hazards on writes not yet committed to the register file.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: asynchronous, active-high reset.
- `a_valid` input 1: execute result valid.
- `a_ready` output 1: execute result accepted this edge when `a_valid & a_ready`.
- `a_local` input 1: 1 = local register, 0 = global register.
- `a_addr` input 8: register number.
- `a_data` input 64: result value.
- `m_valid`, `m_ready`, `m_local`, `m_addr[7:0]`, `m_data[63:0]`: same as the `a_*` ports, for load results.
- `hold` input 1: 1 = do not pop the FIFO this cycle.
- `gregw` output `regwrite` (enable, addr[7:0], data[63:0]): global register write.
- `lregw` output `regwrite`: local register write.
- `q_local` input 1: pending-query register class.
- `q_addr` input 8: pending-query register number.
- `q_pending` output 1: a write to (`q_local`, `q_addr`) is queued or on the output stage.
- `count` output $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Storage: circular FIFO of {local, addr[7:0], data[63:0]}, with wr_ptr, rd_ptr and count registers. Pointers wrap modulo DEPTH.
- Push arbitration:
  - At most one push per cycle. Load path has priority.
  - `m_ready = ~reset & (count < DEPTH)`.
  - `a_ready = ~reset & (count < DEPTH) & ~m_valid`.
  - A push occurs on `m_valid & m_ready`, otherwise on `a_valid & a_ready`.
- Pop:
  - Pop occurs when `count > 0 & ~hold`.
  - The head entry is registered into the output stage:
    - if local = 1, `lregw` gets {1, addr, data} and `gregw.enable` is 0;
    - if local = 0, `gregw` gets {1, addr, data} and `lregw.enable` is 0.
  - In any cycle without a pop, both enables are 0 at the next edge. addr and data hold their last values.
- Simultaneous push and pop: both occur and count is unchanged. This is legal at count = DEPTH only if the push was already allowed; ready is based on current count, so a full FIFO refuses the push even when a pop is happening.
- Ordering: writes retire strictly in acceptance order. Two writes to the same register are never reordered or merged.
- `q_pending`:
  - Combinational OR over all occupied FIFO entries, plus the output stage if its enable is set, of (local == `q_local` & addr == `q_addr`).
  - Entries accepted on the current edge are not visible until after that edge.
- Reset (asynchronous, any time including mid-drain):
  - count = 0, wr_ptr = 0, rd_ptr = 0.
  - `gregw` and `lregw` = {0, 0, 0}.
  - `q_pending` = 0.
  - Queued writes are discarded.
  - `a_ready` = `m_ready` = 0 while reset is high; both are 1 on the first cycle after release.

## Timing
- Push at edge E0 into an empty FIFO with `hold` = 0:
  - count = 1 after E0;
  - pop at E1, with enable high during E1–E2;
  - register-file write at E2.
- Minimum accept-to-commit latency is 2 edges.
- Throughput: 1 write per cycle sustained when pushes and pops overlap.
- `hold` is sampled at the edge; `hold` = 1 freezes rd_ptr and deasserts both enables at that edge.
- count saturates at DEPTH; ready is low while count = DEPTH.
- `q_pending` and the ready signals are combinational from registered state and inputs; no input-to-output path other than q_*/`m_valid` → outputs.

## Test plan
- Reset, then single execute push {local = 0, addr = 0x20, data = 0x1234}:
  - `a_ready` = 1;
  - 2 edges later `gregw` = {1, 0x20, 0x1234} for exactly one cycle;
  - `lregw.enable` = 0 throughout.
- `a_valid` and `m_valid` both high on the same edge, with m = {1, 0x05, 0xAA} and a = {0, 0x06, 0xBB}:
  - `a_ready` = 0 on that cycle and `m_ready` = 1;
  - `lregw` {0x05, 0xAA} commits first, then `gregw` {0x06, 0xBB} after a is re-presented.
- `hold` = 1 with 4 pushes:
  - count = 4 and both ready signals = 0;
  - a 5th valid is held off.
  - Release `hold`: outputs retire in order on 4 consecutive cycles, and count decrements 4→0.
- Continuous push/pop for 10 cycles with addr 0..9:
  - count stays 1 and the pointers wrap past DEPTH;
  - output addr sequence is 0..9 with no gaps.
- Queue {1, 0x30} with `hold` = 1, then query with `q_local` = 1, `q_addr` = 0x30:
  - `q_pending` = 1; it stays 1 during the output-stage cycle and is 0 the cycle after commit;
  - a query with `q_local` = 0, `q_addr` = 0x30 gives 0.
- Assert `reset` asynchronously with count = 3 and the output stage enabled:
  - enables drop immediately, count = 0, `q_pending` = 0;
  - no write is issued after release.
